thumb_fetch: RTL
================

# thumb_fetch

Instruction fetch unit feeding the Thumb decode stage. It issues aligned 32-bit word reads to instruction memory, splits each returned word into two 16-bit Thumb halfwords, and buffers them in a small prefetch FIFO. It presents them one per cycle to decode under a valid/ready handshake, together with each halfword's PC. A redirect input (branch or exception) flushes the buffer and restarts fetch at a new halfword-aligned address, discarding any in-flight memory response.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset; bit 0 ignored.
- FIFO_DEPTH, 4: prefetch buffer depth in halfwords; power of two, ≥ 2.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- mem_req  out  1  read request; held high until granted
- mem_addr  out  32  word address of request; bits [1:0] always 0
- mem_gnt  in  1  memory accepts request this cycle (sampled with mem_req high)
- mem_rvalid  in  1  read data valid; exactly one per granted request, ≥ 1 cycle after gnt
- mem_rdata  in  32  read data, little-endian: [15:0] at addr, [31:16] at addr+2
- redirect  in  1  flush and restart fetch
- redirect_pc  in  32  new fetch PC; bit 0 ignored
- instr_valid  out  1  instruction/instr_pc valid
- instr_ready  in  1  decode consumes head this cycle when instr_valid high
- instruction  out  16  Thumb halfword at FIFO head
- instr_pc  out  32  address of instruction

## Operation

- State machine: IDLE (no request), REQ (mem_req high, awaiting gnt), WAIT (granted, awaiting rvalid).
- IDLE→REQ when free slots ≥ 2, counted after this cycle's pop. REQ→WAIT on mem_gnt. WAIT→IDLE on mem_rvalid, or →REQ on mem_rvalid if the space condition already holds.
- Registers: fetch_addr (word-aligned), drop_low flag, head_pc, discard flag, FIFO count.
- Response (rvalid, discard clear): push rdata[15:0] unless drop_low, then push rdata[31:16]; fetch_addr += 4; drop_low cleared.
- Pop: instr_valid && instr_ready removes head; head_pc += 2. Simultaneous push and pop are allowed.
- Redirect, highest priority, takes effect in the same cycle:
  - FIFO emptied; any pop that cycle is ignored.
  - fetch_addr = {redirect_pc[31:2],2'b0}; drop_low = redirect_pc[1]; head_pc = {redirect_pc[31:1],1'b0}.
  - In REQ with no gnt: stay in REQ; mem_addr shows the new address next cycle. Memory samples the address only on gnt.
  - In REQ with gnt, or in WAIT without rvalid: set discard; the next rvalid is dropped and clears discard.
  - rvalid in the same cycle as redirect: data dropped; discard not set.
- With discard set, a new request may be granted only after the stale response returns. The state stays WAIT until then.
- instruction, instr_pc, and instr_valid reflect FIFO head state; no combinational path from mem_rdata.
- 32-bit address arithmetic wraps modulo 2^32.

## Timing

- Reset values: mem_req 0, mem_addr {RESET_PC[31:2],2'b0}, instr_valid 0, instruction 0, instr_pc {RESET_PC[31:1],1'b0}; FIFO empty; discard 0; drop_low RESET_PC[1]; state IDLE.
- mem_req rises in the first cycle after rst_n deasserts.
- Latency: request granted in cycle N with rvalid in N+1 → instr_valid high in N+2.
- Redirect in cycle R → instr_valid low in R+1. The earliest new mem_req is R+1, unless the request is still ungranted, in which case it continues with the new address.
- Reset asserted mid-transaction: all state returns to reset values immediately. The memory side must not return a response for a pre-reset grant.
- Sustained throughput: 1 halfword/cycle with single-cycle memory and FIFO_DEPTH ≥ 4.

## Structure

- thumb_fetch_pkg: fetch_state_t enum (IDLE, REQ, WAIT); halfword width localparam; word/halfword alignment helpers.
- Sub-module halfword_fifo: 16-bit wide, parameter FIFO_DEPTH. Supports 0/1/2 push per cycle, 1 pop, synchronous flush, count output.
- thumb_fetch: FSM, address/PC registers, discard logic.

## Test plan

- Reset, RESET_PC=0, memory 1-cycle latency, words 0x2222_1111/0x4444_3333, instr_ready=1 → instruction 0x1111@0, 0x2222@2, 0x3333@4, 0x4444@6 on consecutive cycles.
- instr_ready=0 → FIFO fills to 4, mem_req stays low, no overflow; instr_ready=1 → order preserved.
- Redirect to 0x0000_0102 → mem_addr 0x100, first instruction is rdata[31:16] with instr_pc 0x102.
- Redirect while in WAIT (latency 3) → stale rvalid dropped; next instruction comes from the new address; no extra request before the stale response.
- Redirect with instr_valid && instr_ready and rvalid in the same cycle → nothing popped or pushed; instr_valid=0 next cycle.
- rst_n pulse mid-WAIT → outputs at reset values; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/thumb_fetch_pkg.sv
// Shared types and helpers for the Thumb instruction fetch unit.
package thumb_fetch_pkg;

    // Width of one Thumb instruction halfword.
    localparam int HW_W = 16;

    // Memory-side request state: no request, request pending grant, granted awaiting data.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    // Clear the two low bits to form a word address.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // Clear bit 0 to form a halfword address.
    function automatic logic [31:0] hw_align(input logic [31:0] addr);
        return {addr[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/thumb_fetch_halfword_fifo.sv
// Prefetch buffer of Thumb halfwords: up to two pushes and one pop per cycle,
// synchronous flush that overrides any push or pop in the same cycle.
module halfword_fifo
    import thumb_fetch_pkg::*;
#(
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [1:0]       push_cnt_i,
    input  logic [HW_W-1:0]  push_data0_i,
    input  logic [HW_W-1:0]  push_data1_i,
    input  logic             pop_i,
    output logic [HW_W-1:0]  head_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic [HW_W-1:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_nxt;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FIFO_DEPTH-1:0] wr_en0;
    logic [FIFO_DEPTH-1:0] wr_en1;

    // Depth is a power of two, so pointer arithmetic wraps on its own.
    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
        assign wr_en0[gi] = !flush_i && (push_cnt_i != 2'd0) && (wr_ptr_q == PTR_W'(gi));
        assign wr_en1[gi] = !flush_i && (push_cnt_i == 2'd2) && (wr_ptr_nxt == PTR_W'(gi));
    end

    // Slot at the write pointer takes the first halfword, the following slot the second.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_en0[i]) begin
                mem_q[i] <= push_data0_i;
            end else if (wr_en1[i]) begin
                mem_q[i] <= push_data1_i;
            end
        end
    end

    // Next pointer and occupancy values; flush empties the buffer outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
            wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt_i);
            count_d  = count_q + CNT_W'(push_cnt_i) - CNT_W'(pop_i);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

endmodule

// File: rtl/thumb_fetch.sv
// Thumb fetch unit: word reads from instruction memory, split into halfwords,
// buffered and handed to decode with their PCs. Redirect flushes and restarts.
module thumb_fetch
    import thumb_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic [31:0]     mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [31:0]     mem_rdata,
    input  logic            redirect,
    input  logic [31:0]     redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [HW_W-1:0] instruction,
    output logic [31:0]     instr_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;
    // A new request is only issued when a full word (two halfwords) is sure to fit.
    localparam logic [OCC_W-1:0] SPACE_LIMIT = OCC_W'(FIFO_DEPTH - 2);

    fetch_state_t     state_q, state_d;
    logic [31:0]      fetch_addr_q, fetch_addr_d;
    logic [31:0]      head_pc_q, head_pc_d;
    logic             drop_low_q, drop_low_d;
    logic             discard_q, discard_d;

    logic [CNT_W-1:0] fifo_count;
    logic [HW_W-1:0]  head_data;
    logic [HW_W-1:0]  push_data0;
    logic [HW_W-1:0]  push_data1;
    logic [1:0]       push_cnt;
    logic             resp_take;
    logic             pop_take;
    logic [OCC_W-1:0] occ_after;
    logic             space_ok;

    // A response is kept only when it belongs to the current fetch stream.
    assign resp_take = (state_q == WAIT) && mem_rvalid && !discard_q && !redirect;
    assign pop_take  = instr_valid && instr_ready && !redirect;

    // Entering mid-word (odd halfword) skips the low half of the first word.
    assign push_cnt   = resp_take ? (drop_low_q ? 2'd1 : 2'd2) : 2'd0;
    assign push_data0 = drop_low_q ? mem_rdata[31:16] : mem_rdata[15:0];
    assign push_data1 = mem_rdata[31:16];

    // Occupancy once this cycle's push, pop and flush have been applied.
    assign occ_after = redirect ? '0
                     : (OCC_W'(fifo_count) + OCC_W'(push_cnt) - OCC_W'(pop_take));
    assign space_ok  = (occ_after <= SPACE_LIMIT);

    halfword_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect),
        .push_cnt_i   (push_cnt),
        .push_data0_i (push_data0),
        .push_data1_i (push_data1),
        .pop_i        (pop_take),
        .head_data_o  (head_data),
        .count_o      (fifo_count)
    );

    // Request FSM and stale-response tracking.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                if (space_ok) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // An ungranted request simply picks up the new address next cycle;
                // a granted one at the old address must have its data thrown away.
                if (mem_gnt) begin
                    state_d = WAIT;
                    if (redirect) begin
                        discard_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    discard_d = 1'b0;
                    state_d   = space_ok ? REQ : IDLE;
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fetch address, partial-word flag and decode-side PC.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        drop_low_d   = drop_low_q;
        head_pc_d    = head_pc_q;
        if (redirect) begin
            fetch_addr_d = word_align(redirect_pc);
            drop_low_d   = redirect_pc[1];
            head_pc_d    = hw_align(redirect_pc);
        end else begin
            if (resp_take) begin
                fetch_addr_d = fetch_addr_q + 32'd4;
                drop_low_d   = 1'b0;
            end
            if (pop_take) begin
                head_pc_d = head_pc_q + 32'd2;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= word_align(RESET_PC);
            head_pc_q    <= hw_align(RESET_PC);
            drop_low_q   <= RESET_PC[1];
            discard_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            head_pc_q    <= head_pc_d;
            drop_low_q   <= drop_low_d;
            discard_q    <= discard_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = fetch_addr_q;
    assign instr_valid = (fifo_count != '0);
    assign instruction = instr_valid ? head_data : '0;
    assign instr_pc    = head_pc_q;

endmodule
